am_ask_meas_sched: RTL

//  Frame-level scheduler for the AM/ASK demodulation datapath: captures FRAME_LEN ADC samples

---
 rtl/am_ask_meas_sched.sv | 100 ++++++++++
 1 files changed

// File: rtl/am_ask_meas_sched.sv
// am_ask_meas_sched: per-frame scheduler that runs ADC capture, then FFT, then the classifier, then publishes the result.
// Defining SCHED_TIMEOUT_EN adds a done-wait timeout that sets a sticky err_timeout flag.
module am_ask_meas_sched #(
    parameter int FRAME_LEN = 8192,
    parameter int HOLDOFF_CYC = 1024,
    parameter int TIMEOUT_CYC = 65536,
    localparam int AW = $clog2(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          ad_valid,
    output logic          cap_we,
    output logic [AW-1:0] cap_addr,
    output logic          fft_start,
    input  logic          fft_done,
    output logic          cls_start,
    input  logic          cls_done,
    input  logic          cls_is_ask,
    input  logic [3:0]    cls_ma,
    input  logic [7:0]    cls_freq,
    output logic          is_ask,
    output logic [3:0]    ma,
    output logic [7:0]    freq,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy,
    output logic          err_timeout
);
    localparam int HW = $clog2(HOLDOFF_CYC + 1);
    typedef enum logic [2:0] {IDLE, CAPTURE, WAIT_FFT, WAIT_CLS, PUBLISH, HOLDOFF} state_t;
    state_t state, state_nx;
    logic [HW-1:0] hcnt;
    logic fft_ok, cls_ok, tmo;
    assign cap_we = ad_valid && (state == CAPTURE);
    assign busy = state != IDLE;
    // a done seen while the matching start pulse is still high belongs to a previous run
    assign fft_ok = fft_done && !fft_start;
    assign cls_ok = cls_done && !cls_start;
`ifdef SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
    logic err;
    assign tmo = (tcnt == TW'(TIMEOUT_CYC - 1)) &&
                 (((state == WAIT_FFT) && !fft_ok) || ((state == WAIT_CLS) && !cls_ok));
    assign err_timeout = err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
            err <= 1'b0;
        end else begin
            tcnt <= (state_nx != state) ? '0 : tcnt + 1'b1;
            err <= err | tmo;
        end
    end
`else
    assign tmo = 1'b0;
    assign err_timeout = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = en ? CAPTURE : IDLE;
            CAPTURE:  state_nx = (cap_we && (cap_addr == AW'(FRAME_LEN - 1))) ? WAIT_FFT : CAPTURE;
            WAIT_FFT: state_nx = fft_ok ? WAIT_CLS : (tmo ? HOLDOFF : WAIT_FFT);
            WAIT_CLS: state_nx = cls_ok ? PUBLISH : (tmo ? HOLDOFF : WAIT_CLS);
            PUBLISH:  state_nx = res_ready ? HOLDOFF : PUBLISH;
            HOLDOFF:  state_nx = (hcnt == HW'(HOLDOFF_CYC - 1)) ? (en ? CAPTURE : IDLE) : HOLDOFF;
            default:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // cap_addr wraps to 0 on the last write, so every frame starts at address 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr <= '0;
            hcnt <= '0;
            fft_start <= 1'b0;
            cls_start <= 1'b0;
            res_valid <= 1'b0;
            is_ask <= 1'b0;
            ma <= '0;
            freq <= '0;
        end else begin
            cap_addr <= cap_we ? cap_addr + 1'b1 : cap_addr;
            hcnt <= (state == HOLDOFF) ? hcnt + 1'b1 : '0;
            fft_start <= (state == CAPTURE) && (state_nx == WAIT_FFT);
            cls_start <= (state == WAIT_FFT) && (state_nx == WAIT_CLS);
            res_valid <= state_nx == PUBLISH;
            if ((state == WAIT_CLS) && cls_ok) begin
                is_ask <= cls_is_ask;
                ma <= cls_ma;
                freq <= cls_freq;
            end
        end
    end
endmodule
